dmem_responder: RTL
===================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024, SHALL set the RAM depth in 32-bit words (power of two).
REQ-002 Parameter MMIO_BASE, default 32'hFF00_0000, SHALL set the lowest address of the MMIO window.
REQ-003 Ports SHALL be:
- clk_i  in  1  clock; one clock domain.
- reset_i  in  1  synchronous, active-high reset.
- dmem_addr_i  in  32  word-aligned address from the CPU.
- dmem_read_enable_i  in  1  load request.
- dmem_write_data_i  in  32  lane-aligned store data.
- dmem_write_mask_i  in  4  byte-lane write enables.
- dmem_read_data_o  out  32  load data.
- dmem_stall_o  out  1  CPU must hold its request stable.
- mmio_valid_o  out  1  MMIO request valid.
- mmio_ready_i  in  1  MMIO request accepted/completed.
- mmio_addr_o  out  32  MMIO address.
- mmio_read_o  out  1  MMIO request is a read.
- mmio_write_data_o  out  32  MMIO store data.
- mmio_write_mask_o  out  4  MMIO byte lanes.
- mmio_read_data_i  in  32  MMIO read data, sampled with mmio_ready_i.

Function
REQ-004 Access SHALL mean dmem_read_enable_i=1 or dmem_write_mask_i!=0; a nonzero mask is a write and takes precedence over the read enable.
REQ-005 Hit decode: MMIO if dmem_addr_i >= MMIO_BASE, else RAM; RAM index = dmem_addr_i[$clog2(DEPTH_WORDS)+1:2], so the upper bits alias.
REQ-006 RAM write: at the clock edge, byte lane k SHALL be updated iff mask[k]=1; unmasked lanes are preserved.
REQ-007 RAM read latency SHALL be 1 cycle: a read accepted in cycle N gives dmem_read_data_o in N+1.
REQ-008 RAM read and write to the same word in one cycle SHALL be read-first, returning the old data.
REQ-009 dmem_read_data_o SHALL hold its last value in any cycle that completes no read.
REQ-010 The FSM SHALL have three states: IDLE, REQ and DONE.
REQ-011 IDLE -> REQ on an MMIO access; dmem_stall_o SHALL be 1 combinationally in that same cycle.
REQ-012 In REQ:
- mmio_valid_o=1 and dmem_stall_o=1.
- mmio_addr_o, mmio_read_o, mmio_write_data_o and mmio_write_mask_o SHALL come from registers captured on the IDLE->REQ edge.
- These outputs SHALL remain stable until mmio_ready_i=1.
REQ-013 REQ -> DONE on mmio_ready_i=1; mmio_read_data_i SHALL be captured at that edge.
REQ-014 In DONE:
- dmem_stall_o=0 and mmio_valid_o=0.
- The request is considered accepted and SHALL NOT be relaunched.
- Next state is IDLE.
- For a read, the captured data SHALL appear on dmem_read_data_o in the following cycle.
REQ-015 An MMIO round trip with ready in the first REQ cycle SHALL take 3 cycles: IDLE, REQ, DONE.
REQ-016 RAM accesses in IDLE SHALL never stall; back-to-back RAM accesses SHALL sustain one per cycle.
REQ-017 A RAM access presented while the FSM is in DONE SHALL be serviced normally.

Reset
REQ-018 While reset_i=1 at an edge, the following SHALL be forced:
- state=IDLE.
- mmio_valid_o=0, mmio_read_o=0, mmio_write_mask_o=0.
- dmem_read_data_o=0.
REQ-019 dmem_stall_o SHALL be 0 while reset_i=1.
REQ-020 Reset during REQ SHALL abandon the transfer; mmio_valid_o=0 from the next cycle, and a late mmio_ready_i SHALL be ignored.
REQ-021 RAM contents SHALL NOT be reset.

Configuration
REQ-022 Macro DMEM_MMIO_EN:
- Defined: the MMIO window and FSM are present as specified.
- Undefined: all addresses decode to RAM via aliasing.
- Undefined: dmem_stall_o, mmio_valid_o and all other mmio_* outputs are tied to 0, and the FSM is absent.

Verification
REQ-023 Write addr 0x10, data 0xAABBCCDD, mask 1111; then read 0x10 -> data 0xAABBCCDD one cycle later, stall never 1.
REQ-024 After REQ-023, write data 0x00001100, mask 0010; read 0x10 -> 0xAABB11DD.
REQ-025 Same cycle: read 0x20 (old value 0x12345678) and write 0xFFFFFFFF mask 1111 to 0x20 -> returns 0x12345678; the next read returns 0xFFFFFFFF.
REQ-026 Read 0xFF000004; ready held low 3 cycles, then high with data 0xCAFEF00D:
- Stall for 5 cycles total.
- mmio_addr_o stays stable at 0xFF000004.
- Data 0xCAFEF00D appears in the cycle after DONE.
REQ-027 Start an MMIO write; assert reset in the second REQ cycle; raise ready afterwards -> mmio_valid_o=0 and stall=0 after reset, and no state change.
REQ-028 Without DMEM_MMIO_EN: write 0xFF000004 with 0x55 mask 0001 -> stall stays 0 and RAM word 1 changes.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory responder: 1-cycle byte-maskable RAM with an optional MMIO window behind an IDLE/REQ/DONE handshake.
// Define DMEM_MMIO_EN to enable the MMIO window; otherwise every address aliases into RAM and the mmio_* outputs are 0.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] MMIO_BASE   = 32'hFF00_0000
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [31:0] dmem_addr_i,
    input  logic        dmem_read_enable_i,
    input  logic [31:0] dmem_write_data_i,
    input  logic [3:0]  dmem_write_mask_i,
    output logic [31:0] dmem_read_data_o,
    output logic        dmem_stall_o,
    output logic        mmio_valid_o,
    input  logic        mmio_ready_i,
    output logic [31:0] mmio_addr_o,
    output logic        mmio_read_o,
    output logic [31:0] mmio_write_data_o,
    output logic [3:0]  mmio_write_mask_o,
    input  logic [31:0] mmio_read_data_i
);
    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    logic [31:0]   r_mem [DEPTH_WORDS];
    logic [31:0]   r_rdata;
    logic [AW-1:0] w_idx;
    logic          w_access;
    logic          w_ram_en;
    logic          w_mmio_deliver;
    logic [31:0]   w_mmio_rdata;

    assign w_idx    = dmem_addr_i[AW+1:2];
    assign w_access = dmem_read_enable_i | (|dmem_write_mask_i);

`ifdef DMEM_MMIO_EN
    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t      r_state;
    logic        r_valid;
    logic        r_read;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wmask;
    logic [31:0] r_mmio_rdata;
    logic        w_is_mmio;
    logic        w_start;

    assign w_is_mmio      = dmem_addr_i >= MMIO_BASE;
    assign w_start        = (r_state == IDLE) && w_access && w_is_mmio;
    // The CPU is frozen in REQ, so only IDLE and DONE may touch the RAM.
    assign w_ram_en       = (r_state != REQ) && !w_is_mmio;
    assign w_mmio_deliver = (r_state == DONE) && r_read;
    assign w_mmio_rdata   = r_mmio_rdata;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state      <= IDLE;
            r_valid      <= 1'b0;
            r_read       <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_wmask      <= '0;
            r_mmio_rdata <= '0;
        end else begin
            case (r_state)
                IDLE: if (w_start) begin
                    r_addr  <= dmem_addr_i;
                    r_read  <= ~(|dmem_write_mask_i);
                    r_wdata <= dmem_write_data_i;
                    r_wmask <= dmem_write_mask_i;
                    r_valid <= 1'b1;
                    r_state <= REQ;
                end
                REQ: if (mmio_ready_i) begin
                    r_valid      <= 1'b0;
                    r_mmio_rdata <= mmio_read_data_i;
                    r_state      <= DONE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign dmem_stall_o      = !reset_i && (w_start || (r_state == REQ));
    assign mmio_valid_o      = r_valid;
    assign mmio_addr_o       = r_addr;
    assign mmio_read_o       = r_read;
    assign mmio_write_data_o = r_wdata;
    assign mmio_write_mask_o = r_wmask;
`else
    logic w_unused_mmio;

    assign w_ram_en          = 1'b1;
    assign w_mmio_deliver    = 1'b0;
    assign w_mmio_rdata      = '0;
    assign dmem_stall_o      = 1'b0;
    assign mmio_valid_o      = 1'b0;
    assign mmio_addr_o       = '0;
    assign mmio_read_o       = 1'b0;
    assign mmio_write_data_o = '0;
    assign mmio_write_mask_o = '0;
    assign w_unused_mmio     = ^{mmio_ready_i, mmio_read_data_i, dmem_addr_i, MMIO_BASE, w_access};
`endif

    always_ff @(posedge clk_i) begin
        if (!reset_i && w_ram_en) begin
            for (int k = 0; k < 4; k++) begin
                if (dmem_write_mask_i[k]) r_mem[w_idx][8*k +: 8] <= dmem_write_data_i[8*k +: 8];
            end
        end
    end

    // Read-first: the array read sees the pre-edge contents even when the same word is written.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_rdata <= '0;
        end else if (w_mmio_deliver) begin
            r_rdata <= w_mmio_rdata;
        end else if (w_ram_en && dmem_read_enable_i) begin
            r_rdata <= r_mem[w_idx];
        end
    end

    assign dmem_read_data_o = r_rdata;
endmodule
